// File: rtl/sram_obi_pkg.sv
// Shared types for the OBI-to-SRAM bridge: FSM states, response entry layout
// and the handshake parity helper.
package sram_obi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_e;

  // Response entry layout at the default 32-bit data width; the top builds the
  // same {data, err, we} layout at its configured width.
  localparam int RSP_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RSP_DATA_WIDTH-1:0] data;
    logic                      err;
    logic                      we;
  } rsp_entry_t;

  // A handshake signal and its inverted copy must always differ.
  function automatic logic hs_pair_ok(input logic sig, input logic inv);
    return sig ^ inv;
  endfunction

endpackage

// File: rtl/sram_obi_rsp_fifo.sv
// Two-entry response FIFO with registered storage; the head entry is read
// straight from a storage register.
module sram_obi_rsp_fifo #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign do_pop_s  = pop & ~empty;
  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push_s = push & (~full | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_obi_bridge.sv
// OBI front-end for the single-port SRAM wrapper: range check, one outstanding
// SRAM access, buffered responses. Optional feature macro: SRAM_PARITY_CHK_EN.
module sram_obi_bridge
  import sram_obi_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 1024,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         obi_req_i,
  output logic                         obi_gnt_o,
  input  logic [ADDR_WIDTH-1:0]        obi_addr_i,
  input  logic                         obi_we_i,
  input  logic [DATA_WIDTH/8-1:0]      obi_be_i,
  input  logic [DATA_WIDTH-1:0]        obi_wdata_i,
  output logic                         obi_rvalid_o,
  input  logic                         obi_rready_i,
  output logic [DATA_WIDTH-1:0]        obi_rdata_o,
  output logic                         obi_err_o,
  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic                         sram_rready_o,
  output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0]        sram_wdata_o,
  output logic [DATA_WIDTH/8-1:0]      sram_be_o,
  input  logic [DATA_WIDTH-1:0]        sram_rdata_i,
  input  logic                         sram_gnt_i,
  input  logic                         sram_gntpar_i,
  input  logic                         sram_rvalid_i,
  input  logic                         sram_rvalidpar_i,
  output logic                         parity_err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int SRAM_AW  = $clog2(NUM_WORDS);
  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(NUM_WORDS * BE_WIDTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  err;
    logic                  we;
  } rsp_t;

  localparam int RSP_WIDTH = $bits(rsp_t);

  state_e                state_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic                  in_range_s;
  logic                  idle_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  hs_err_s;
  rsp_t                  push_entry_s;
  rsp_t                  head_s;

  // The lower-bound test keeps addresses below the base from wrapping into range.
  assign offset_s   = obi_addr_i - BASE_ADDR;
  assign in_range_s = (obi_addr_i >= BASE_ADDR) && ({1'b0, offset_s} < MEM_BYTES);
  assign idle_s     = (state_r == IDLE);

  assign obi_gnt_o     = idle_s & obi_req_i & ~fifo_full_s & (sram_gnt_i | ~in_range_s);
  assign sram_req_o    = idle_s & obi_req_i & in_range_s & ~fifo_full_s;
  assign sram_we_o     = obi_we_i;
  assign sram_addr_o   = offset_s[OFF_BITS +: SRAM_AW];
  assign sram_wdata_o  = obi_wdata_i;
  assign sram_be_o     = obi_be_i;
  assign sram_rready_o = 1'b1;

  // Transaction FSM; remembers the access direction for the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (obi_gnt_o) begin
            we_r    <= obi_we_i;
            state_r <= in_range_s ? ACCESS : ERR;
          end
        end
        ACCESS: begin
          if (sram_rvalid_i) begin
            state_r <= IDLE;
          end
        end
        ERR:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Response entry built from the SRAM return or the range error.
  always_comb begin
    push_s       = 1'b0;
    push_entry_s = '0;
    case (state_r)
      ACCESS: begin
        push_s            = sram_rvalid_i;
        push_entry_s.data = we_r ? '0 : sram_rdata_i;
        push_entry_s.err  = hs_err_s;
        push_entry_s.we   = we_r;
      end
      ERR: begin
        push_s           = 1'b1;
        push_entry_s.err = 1'b1;
        push_entry_s.we  = we_r;
      end
      default: begin
        push_s       = 1'b0;
        push_entry_s = '0;
      end
    endcase
  end

  sram_obi_rsp_fifo #(
    .WIDTH(RSP_WIDTH)
  ) u_rsp_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign obi_rvalid_o = ~fifo_empty_s;
  assign pop_s        = obi_rvalid_o & obi_rready_i;
  assign obi_rdata_o  = (obi_rvalid_o & ~head_s.we) ? head_s.data : '0;
  assign obi_err_o    = obi_rvalid_o & head_s.err;

`ifdef SRAM_PARITY_CHK_EN
  logic parity_err_r;

  assign hs_err_s = ~hs_pair_ok(sram_gnt_i, sram_gntpar_i)
                  | ~hs_pair_ok(sram_rvalid_i, sram_rvalidpar_i);

  // Sticky handshake parity flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_r <= 1'b0;
    end else if (hs_err_s) begin
      parity_err_r <= 1'b1;
    end
  end

  assign parity_err_o = parity_err_r;
`else
  // Parity copies are ignored; the AND keeps them referenced.
  assign hs_err_s     = 1'b0 & (sram_gntpar_i ^ sram_rvalidpar_i);
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_obi_bridge.sv
// Directed, table-driven bench for sram_obi_bridge with a behavioural SRAM.
module tb_sram_obi_bridge;

  localparam logic [31:0] BASE = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_rready, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [3:0]  obi_be;
  logic        sram_req, sram_we, sram_rready, sram_gnt, sram_gntpar;
  logic        sram_rvalid, sram_rvalidpar, parity_err;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_be;
  logic        force_par;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];
  logic [31:0] mem [1024];

  sram_obi_bridge #(
    .DATA_WIDTH(32), .NUM_WORDS(1024), .ADDR_WIDTH(32), .BASE_ADDR(BASE)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_rvalid_o(obi_rvalid), .obi_rready_i(obi_rready),
    .obi_rdata_o(obi_rdata), .obi_err_o(obi_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_rready_o(sram_rready),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata), .sram_gnt_i(sram_gnt), .sram_gntpar_i(sram_gntpar),
    .sram_rvalid_i(sram_rvalid), .sram_rvalidpar_i(sram_rvalidpar),
    .parity_err_o(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign sram_gnt       = 1'b1;
  assign sram_gntpar    = force_par ? sram_gnt : ~sram_gnt;
  assign sram_rvalidpar = ~sram_rvalid;

  // Behavioural SRAM: grants immediately, answers one cycle later, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_rvalid <= 1'b0;
      sram_rdata  <= 32'h0;
      for (int w = 0; w < 1024; w++) mem[w] <= 32'h0;
    end else begin
      sram_rvalid <= 1'b0;
      if (sram_req && sram_gnt) begin
        sram_rvalid <= 1'b1;
        if (sram_we) begin
          for (int b = 0; b < 4; b++)
            if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
        end else begin
          sram_rdata <= mem[sram_addr];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    int gc;
    int reqs;
    @(negedge clk);
    obi_req = 1'b1; obi_we = v.we; obi_addr = v.addr; obi_be = v.be; obi_wdata = v.wdata;
    #1;
    n = 0; reqs = 0;
    while (!obi_gnt && n < 20) begin
      if (sram_req) reqs++;
      @(negedge clk); #1; n++;
    end
    if (!obi_gnt) begin
      chk({nm, "_gnt"}, {31'b0, obi_gnt}, 32'd1);
      obi_req = 1'b0;
      return;
    end
    if (sram_req) reqs++;
    gc = cyc;
    @(negedge clk);
    obi_req = 1'b0;
    #1;
    n = 0;
    while (!obi_rvalid && n < 20) begin
      if (sram_req) reqs++;
      @(negedge clk); #1; n++;
    end
    chk({nm, "_rvalid"}, {31'b0, obi_rvalid}, 32'd1);
    chk({nm, "_lat"}, cyc - gc, 32'd2);
    chk({nm, "_rdata"}, obi_rdata, v.exp_rdata);
    chk({nm, "_err"}, {31'b0, obi_err}, {31'b0, v.exp_err});
    chk({nm, "_sram_req"}, reqs, v.exp_err ? 32'd0 : 32'd1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_gnt"}, {31'b0, obi_gnt}, 32'd0);
    chk({nm, "_rvalid"}, {31'b0, obi_rvalid}, 32'd0);
    chk({nm, "_rdata"}, obi_rdata, 32'd0);
    chk({nm, "_err"}, {31'b0, obi_err}, 32'd0);
    chk({nm, "_sram_req"}, {31'b0, sram_req}, 32'd0);
    chk({nm, "_parity"}, {31'b0, parity_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int held;
    int ngot;
    bit cg;
    logic [31:0] got [3];
    logic [31:0] exp_bp [3];
    logic exp_par;
    vec_t v;

    vecs[0]  = '{1'b1, BASE + 32'h010,  4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b0, BASE + 32'h010,  4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, BASE + 32'h020,  4'hF, 32'h1111_1111, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, BASE + 32'h020,  4'b0010, 32'h0000_AB00, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, BASE + 32'h020,  4'hF, 32'h0000_0000, 32'h1111_AB11, 1'b0};
    vecs[5]  = '{1'b1, BASE + 32'hFFC,  4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b0, BASE + 32'hFFC,  4'hF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b0, BASE + 32'h1000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b1, BASE - 32'h4,    4'hF, 32'h5555_AAAA, 32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b0, BASE + 32'h000,  4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b0, BASE + 32'h011,  4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFF0,   4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; obi_req = 1'b0; obi_we = 1'b0; obi_addr = 32'h0;
    obi_be = 4'h0; obi_wdata = 32'h0; obi_rready = 1'b1; force_par = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    // Back-pressure: two responses buffered, third request held until a pop.
    exp_bp[0] = 32'hDEAD_BEEF; exp_bp[1] = 32'h1111_AB11; exp_bp[2] = 32'hCAFE_F00D;
    @(negedge clk);
    obi_rready = 1'b0; obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF; obi_addr = BASE + 32'h010;
    #1;
    n = 0;
    while (!obi_gnt && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_gnt_a", {31'b0, obi_gnt}, 32'd1);
    @(negedge clk);
    obi_addr = BASE + 32'h020;
    #1;
    n = 0;
    while (!obi_gnt && n < 20) begin @(negedge clk); #1; n++; end
    chk("bp_gnt_b", {31'b0, obi_gnt}, 32'd1);
    @(negedge clk);
    obi_addr = BASE + 32'hFFC;
    #1;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      if (obi_gnt) held++;
      @(negedge clk); #1;
    end
    chk("bp_third_held", held, 32'd0);
    chk("bp_full_rvalid", {31'b0, obi_rvalid}, 32'd1);
    obi_rready = 1'b1;
    ngot = 0; cg = 1'b0;
    got[0] = 32'h0; got[1] = 32'h0; got[2] = 32'h0;
    for (int i = 0; i < 30 && ngot < 3; i++) begin
      if (obi_rvalid) begin
        got[ngot] = obi_rdata;
        ngot++;
      end
      if (obi_gnt) cg = 1'b1;
      @(negedge clk);
      if (cg) obi_req = 1'b0;
      #1;
    end
    obi_req = 1'b0;
    chk("bp_third_granted", {31'b0, cg}, 32'd1);
    chk("bp_rsp_count", ngot, 32'd3);
    for (int k = 0; k < 3; k++) chk($sformatf("bp_rsp%0d", k), got[k], exp_bp[k]);

    // Reset while the SRAM access is in flight.
    @(negedge clk);
    obi_req = 1'b1; obi_we = 1'b0; obi_addr = BASE + 32'h010;
    #1;
    chk("rst_pre_gnt", {31'b0, obi_gnt}, 32'd1);
    @(negedge clk);
    obi_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    held = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (obi_rvalid) held++;
    end
    chk("rst_lost_rsp", held, 32'd0);
    v = '{1'b1, BASE + 32'h040, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b0};
    run_txn(v, "post_rst_wr");
    v = '{1'b0, BASE + 32'h040, 4'hF, 32'h0000_0000, 32'h1234_5678, 1'b0};
    run_txn(v, "post_rst_rd");

    // Single-cycle grant parity fault.
`ifdef SRAM_PARITY_CHK_EN
    exp_par = 1'b1;
`else
    exp_par = 1'b0;
`endif
    @(negedge clk);
    force_par = 1'b1;
    #1;
    chk("par_same_cycle", {31'b0, parity_err}, 32'd0);
    @(negedge clk);
    force_par = 1'b0;
    #1;
    chk("par_next_cycle", {31'b0, parity_err}, {31'b0, exp_par});
    repeat (3) @(negedge clk);
    #1;
    chk("par_sticky", {31'b0, parity_err}, {31'b0, exp_par});
    rst_n = 1'b0;
    #1;
    chk("par_reset", {31'b0, parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
